// File: rtl/tone_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_seq_pkg
// Description : Shared types and default parameters for the tone sequencer.
//               Provides the sequencer state encoding and the default slot
//               count / field widths used by tone_sequencer and tone_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_seq_pkg;

  localparam int DEF_NUM_NOTES = 6;
  localparam int DEF_NOTE_W    = 8;
  localparam int DEF_DUR_W     = 36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FINISH = 2'd2
  } tone_seq_state_t;

endpackage : tone_seq_pkg
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tone_gen
// Description : Square-wave generator. pwm toggles every half_period clocks
//               while enabled; half_period == 0 is a rest (pwm held low,
//               counter held at 0). clear restarts the tone in phase.
// Ports       : clk         - system clock
//               reset       - asynchronous active-high reset
//               enable      - advance the tone counter this cycle
//               clear       - force counter and pwm to 0 (priority)
//               half_period - tone half-period N in clocks
//               pwm         - registered square-wave output
// Revision    : 1.0 - initial release
// ============================================================================
module tone_gen #(
  parameter int NOTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NOTE_W-1:0] half_period,
  output logic              pwm
);

  logic [NOTE_W-1:0] cnt_q, cnt_d;
  logic              pwm_q, pwm_d;

  always_comb begin
    cnt_d = cnt_q;
    pwm_d = pwm_q;
    if (clear || (enable && (half_period == '0))) begin
      cnt_d = '0;
      pwm_d = 1'b0;
    end else if (enable) begin
      if (cnt_q == half_period - 1'b1) begin
        cnt_d = '0;
        pwm_d = ~pwm_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule : tone_gen
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tone_sequencer
// Description : Plays a latched list of NUM_NOTES square-wave tones, each for
//               note_dur clocks (0 treated as 1). Zero-valued notes are rests.
//               Provides busy/done handshaking and a synchronous stop abort.
// Config      : TONE_SEQ_LOOP_EN - when defined, adds input 'loop'; loop=1 at
//               the end of the last note restarts from slot 0 without done.
// Ports       : clk, reset (async, active-high)
//               start    - begin playback (sampled in IDLE)
//               stop     - abort to IDLE (wins over start)
//               notes    - packed note half-periods, slot 0 in LSBs
//               note_dur - clocks per note
//               busy     - high while playing
//               done     - one-cycle pulse after the last note
//               note_idx - slot currently playing
//               pwm      - speaker output
// Revision    : 1.0 - initial release
// ============================================================================
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter  int NUM_NOTES = DEF_NUM_NOTES,
  parameter  int NOTE_W    = DEF_NOTE_W,
  parameter  int DUR_W     = DEF_DUR_W,
  localparam int IDX_W     = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
`ifdef TONE_SEQ_LOOP_EN
  input  logic                        loop,
`endif
  input  logic [NUM_NOTES*NOTE_W-1:0] notes,
  input  logic [DUR_W-1:0]            note_dur,
  output logic                        busy,
  output logic                        done,
  output logic [IDX_W-1:0]            note_idx,
  output logic                        pwm
);

  tone_seq_state_t             state_q;
  logic [NUM_NOTES*NOTE_W-1:0] notes_q;
  logic [DUR_W-1:0]            dur_q;
  logic [DUR_W-1:0]            dur_cnt_q;
  logic [IDX_W-1:0]            note_idx_q;
  logic                        busy_q;
  logic                        done_q;

  logic [NOTE_W-1:0]           w_note;
  logic                        w_dur_last;
  logic                        w_last_idx;
  logic                        w_loop;
  logic                        w_tone_en;
  logic                        w_tone_clr;

`ifdef TONE_SEQ_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  // Half-period of the slot currently playing.
  always_comb begin
    w_note = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (note_idx_q == IDX_W'(i)) begin
        w_note = notes_q[i*NOTE_W +: NOTE_W];
      end
    end
  end

  // A latched duration of 0 behaves as 1: every cycle is the last.
  assign w_dur_last = (dur_q == '0) ? 1'b1 : (dur_cnt_q == dur_q - 1'b1);
  assign w_last_idx = (note_idx_q == IDX_W'(NUM_NOTES - 1));

  // The tone restarts in phase whenever a note boundary, abort or
  // non-playing state is seen, so every note begins with pwm low.
  assign w_tone_en  = (state_q == PLAY);
  assign w_tone_clr = (state_q != PLAY) || stop || w_dur_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      notes_q    <= '0;
      dur_q      <= '0;
      dur_cnt_q  <= '0;
      note_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q    <= PLAY;
            busy_q     <= 1'b1;
            notes_q    <= notes;
            dur_q      <= note_dur;
            note_idx_q <= '0;
            dur_cnt_q  <= '0;
          end
        end
        PLAY: begin
          if (stop) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            note_idx_q <= '0;
            dur_cnt_q  <= '0;
          end else if (w_dur_last) begin
            dur_cnt_q <= '0;
            if (!w_last_idx) begin
              note_idx_q <= note_idx_q + 1'b1;
            end else if (w_loop) begin
              note_idx_q <= '0;
            end else begin
              state_q <= FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            dur_cnt_q <= dur_cnt_q + 1'b1;
          end
        end
        FINISH: begin
          state_q    <= IDLE;
          note_idx_q <= '0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          note_idx_q <= '0;
          dur_cnt_q  <= '0;
        end
      endcase
    end
  end

  tone_gen #(
    .NOTE_W (NOTE_W)
  ) u_tone_gen (
    .clk         (clk),
    .reset       (reset),
    .enable      (w_tone_en),
    .clear       (w_tone_clr),
    .half_period (w_note),
    .pwm         (pwm)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = note_idx_q;

endmodule : tone_sequencer
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_sequencer
// Description : Self-checking bench for tone_sequencer. A driver issues
//               per-cycle stimulus and pushes the expected post-edge outputs
//               computed from a playback-time model; a monitor pops and
//               compares one entry after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

  localparam int NUM   = 6;
  localparam int NW    = 8;
  localparam int DW    = 36;
  localparam int IW    = 3;
  localparam int NBITS = NUM * NW;
`ifdef TONE_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_r = 1'b0;
  logic [NBITS-1:0] notes_r = '0;
  logic [DW-1:0]    dur_r = '0;
  logic             busy, done, pwm;
  logic [IW-1:0]    note_idx;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [IW-1:0] idx;
    logic          pwm;
    logic          chk_idx;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Playback model: mode 0 idle, 1 playing, 2 done cycle.
  int     m_mode = 0;
  longint m_t = 0;
  longint m_D = 1;
  int     m_notes[NUM];
  bit     m_idx_known = 1'b1;

  always #5 clk = ~clk;

  tone_sequencer #(
    .NUM_NOTES (NUM),
    .NOTE_W    (NW),
    .DUR_W     (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
`ifdef TONE_SEQ_LOOP_EN
    .loop     (loop_r),
`endif
    .notes    (notes_r),
    .note_dur (dur_r),
    .busy     (busy),
    .done     (done),
    .note_idx (note_idx),
    .pwm      (pwm)
  );

  function automatic exp_t idle_exp(input bit known);
    exp_t e;
    e.busy = 1'b0; e.done = 1'b0; e.idx = '0; e.pwm = 1'b0; e.chk_idx = known;
    return e;
  endfunction

  // Outputs t cycles into playback: note t/D, position t%D within it;
  // pwm is high during odd multiples of N within the note.
  function automatic exp_t play_exp(input longint t);
    exp_t   e;
    int     i;
    longint j;
    int     n;
    i = int'(t / m_D);
    j = t % m_D;
    n = m_notes[i];
    e.busy = 1'b1; e.done = 1'b0; e.idx = IW'(i); e.chk_idx = 1'b1;
    e.pwm  = (n == 0) ? 1'b0 : (((j / n) % 2) == 1);
    return e;
  endfunction

  task automatic model_step(input bit st, input bit sp, input bit lp);
    exp_t e;
    bit   lpe;
    lpe = lp & LOOP_EN;
    e = idle_exp(m_idx_known);
    case (m_mode)
      0: begin
        if (st && !sp) begin
          for (int s = 0; s < NUM; s++) m_notes[s] = int'(notes_r[s*NW +: NW]);
          m_D    = (dur_r == '0) ? 1 : longint'(dur_r);
          m_t    = 0;
          m_mode = 1;
          e = play_exp(0);
        end
      end
      1: begin
        if (sp) begin
          m_mode = 0; m_idx_known = 1'b1;
          e = idle_exp(1'b1);
        end else if (m_t == NUM * m_D - 1) begin
          if (lpe) begin
            m_t = 0;
            e = play_exp(0);
          end else begin
            m_mode = 2;
            e.busy = 1'b0; e.done = 1'b1; e.idx = IW'(NUM - 1);
            e.pwm = 1'b0; e.chk_idx = 1'b1;
          end
        end else begin
          m_t = m_t + 1;
          e = play_exp(m_t);
        end
      end
      default: begin
        m_mode = 0;
        m_idx_known = sp;
        e = idle_exp(m_idx_known);
      end
    endcase
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit st, input bit sp, input bit lp);
    @(negedge clk);
    if (!st) begin
      notes_r = NBITS'({$urandom(), $urandom()});
      dur_r   = DW'({$urandom(), $urandom()});
    end
    start  = st;
    stop   = sp;
    loop_r = lp;
    model_step(st, sp, lp);
    @(posedge clk);
  endtask

  task automatic load(input int a[NUM], input longint d);
    for (int s = 0; s < NUM; s++) notes_r[s*NW +: NW] = NW'(a[s]);
    dur_r = DW'(d);
  endtask

  task automatic run_play(input int max_cyc, input bit spurious, input int stop_at,
                          input bit lp);
    int k;
    k = 0;
    while (m_mode != 0 && k < max_cyc) begin
      cycle(spurious && ($urandom_range(0, 7) == 0), k == stop_at, lp);
      k++;
    end
  endtask

  // Monitor: one comparison after every edge for which an expectation exists.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (busy !== e.busy || done !== e.done || pwm !== e.pwm ||
            (e.chk_idx && note_idx !== e.idx)) begin
          errors++;
          $display("FAIL trace @%0t: got busy=%0b done=%0b idx=%0d pwm=%0b, want busy=%0b done=%0b idx=%0d%s pwm=%0b",
                   $time, busy, done, note_idx, pwm, e.busy, e.done, e.idx,
                   e.chk_idx ? "" : "(any)", e.pwm);
        end
      end
    end
  end

  initial begin
    int a[NUM];
    int sa;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Reference song with spurious starts and input churn during play.
    a = '{5, 10, 8, 15, 5, 5};
    load(a, 20);
    cycle(1'b1, 1'b0, 1'b0);
    run_play(200, 1'b1, -1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Rest in slot 2.
    a = '{4, 4, 0, 4, 4, 4};
    load(a, 12);
    cycle(1'b1, 1'b0, 1'b0);
    run_play(200, 1'b0, -1, 1'b0);

    // Stop sampled 30 edges after start, then an immediate restart.
    a = '{5, 10, 8, 15, 5, 5};
    load(a, 20);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (29) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    a = '{4, 4, 0, 4, 4, 4};
    load(a, 12);
    cycle(1'b1, 1'b0, 1'b0);
    run_play(200, 1'b0, -1, 1'b0);

    // Simultaneous start and stop in IDLE: stays idle.
    load(a, 12);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Zero duration: one cycle per note.
    a = '{1, 2, 3, 0, 1, 7};
    load(a, 0);
    cycle(1'b1, 1'b0, 1'b0);
    run_play(20, 1'b0, -1, 1'b0);

    // Asynchronous reset during note 3.
    a = '{5, 10, 8, 15, 5, 5};
    load(a, 20);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (65) cycle(1'b0, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, note_idx, pwm} !== '0) begin
      errors++;
      $display("FAIL async-reset: got busy=%0b done=%0b idx=%0d pwm=%0b, want all 0",
               busy, done, note_idx, pwm);
    end
    m_mode = 0; m_idx_known = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    a = '{3, 0, 2, 1, 6, 9};
    load(a, 7);
    cycle(1'b1, 1'b0, 1'b0);
    run_play(100, 1'b0, -1, 1'b0);

    // Loop: wraps twice, then loop dropped to finish.
    a = '{2, 3, 0, 1, 4, 2};
    load(a, 3);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (2 * NUM * 3 + 4) cycle(1'b0, 1'b0, 1'b1);
    run_play(100, 1'b0, -1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Randomized songs, durations, spurious starts, occasional stop.
    for (int r = 0; r < 25; r++) begin
      for (int s = 0; s < NUM; s++)
        a[s] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
      load(a, longint'($urandom_range(0, 20)));
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 100)) : -1;
      cycle(1'b1, 1'b0, 1'b0);
      run_play(1000, 1'b1, sa, 1'b0);
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tone_sequencer
`default_nettype wire
